// File: rtl/usb_proto_defs.sv
// rtl/usb_proto_defs.sv - FT245 link protocol definitions shared by uplink and downlink
package usb_proto_defs;

  localparam logic [7:0] SYNC_BYTE = 8'hC3;
  localparam int         FRAME_LEN = 6;

  typedef enum logic [2:0] {F_SYNC, F_AH, F_AL, F_DH, F_DL, F_SUM} frame_state_e;

  typedef enum logic [1:0] {B_IDLE, B_REQ, B_STROBE, B_RECOVER} byte_state_e;

  typedef enum logic [1:0] {
    PKT_ADDR   = 2'b00,
    PKT_READ   = 2'b01,
    PKT_WRITE  = 2'b10,
    PKT_TSTAMP = 2'b11
  } pkt_type_e;

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/ft245_rx_byte.sv
// rtl/ft245_rx_byte.sv - FT245 receive FIFO byte reader with bus arbitration and RD# timing
module ft245_rx_byte
  import usb_proto_defs::*;
#(
  parameter int RD_LOW_CYCLES  = 4,
  parameter int RD_HIGH_CYCLES = 5
) (
  input  logic       mclk,
  input  logic       reset_n,
  input  logic [7:0] usb_d_in,
  input  logic       usb_rxf_n,
  output logic       usb_rd_n,
  output logic       bus_req,
  input  logic       bus_grant,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  localparam int MAXC = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  byte_state_e   state_q;
  logic          rxf_meta_q, rxf_sync_q;
  logic [CW-1:0] cnt_q;
  logic          rd_n_q, req_q, valid_q;
  logic [7:0]    data_q;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= B_IDLE;
      rxf_meta_q <= 1'b1;
      rxf_sync_q <= 1'b1;
      cnt_q      <= '0;
      rd_n_q     <= 1'b1;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      rxf_meta_q <= usb_rxf_n;
      rxf_sync_q <= rxf_meta_q;
      valid_q    <= 1'b0;
      case (state_q)
        B_IDLE: begin
          if (!rxf_sync_q) begin
            req_q   <= 1'b1;
            state_q <= B_REQ;
          end
        end
        B_REQ: begin
          if (bus_grant) begin
            rd_n_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= B_STROBE;
          end
        end
        // Grant is no longer consulted once the strobe has started.
        B_STROBE: begin
          if (cnt_q == CW'(RD_LOW_CYCLES - 1)) begin
            data_q  <= usb_d_in;
            valid_q <= 1'b1;
            rd_n_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= B_RECOVER;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        B_RECOVER: begin
          if (cnt_q == CW'(RD_HIGH_CYCLES - 1)) begin
            req_q   <= 1'b0;
            state_q <= B_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= B_IDLE;
      endcase
    end
  end

  assign usb_rd_n   = rd_n_q;
  assign bus_req    = req_q;
  assign byte_data  = data_q;
  assign byte_valid = valid_q;

endmodule

// File: rtl/usb_cmd_rx.sv
// rtl/usb_cmd_rx.sv - host command receiver: frames FT245 bytes into checksummed config writes
module usb_cmd_rx
  import usb_proto_defs::*;
#(
  parameter int         RD_LOW_CYCLES  = 4,
  parameter int         RD_HIGH_CYCLES = 5,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter logic [7:0] SYNC_BYTE      = usb_proto_defs::SYNC_BYTE
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [7:0]  usb_d_in,
  input  logic        usb_rxf_n,
  output logic        usb_rd_n,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [15:0] config_addr,
  output logic [15:0] config_data,
  output logic        config_strobe,
  output logic [7:0]  err_count,
  output logic        rx_busy
);

  logic [7:0] byte_data;
  logic       byte_valid;

  ft245_rx_byte #(
    .RD_LOW_CYCLES (RD_LOW_CYCLES),
    .RD_HIGH_CYCLES(RD_HIGH_CYCLES)
  ) u_rx_byte (
    .mclk      (mclk),
    .reset_n   (reset_n),
    .usb_d_in  (usb_d_in),
    .usb_rxf_n (usb_rxf_n),
    .usb_rd_n  (usb_rd_n),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .byte_data (byte_data),
    .byte_valid(byte_valid)
  );

  frame_state_e fstate_q;
  logic [7:0]   addr_hi_q, addr_lo_q, data_hi_q, data_lo_q, sum_q;
  logic [15:0]  tmo_q;
  logic [15:0]  cfg_addr_q, cfg_data_q;
  logic         strobe_q;
  logic [7:0]   err_q, err_d;
  logic         bad_sync, bad_sum, timeout, err_event;

  // Timeout needs an idle cycle, so it can never coincide with a checksum error.
  always_comb begin
    bad_sync  = byte_valid && (fstate_q == F_SYNC) && (byte_data != SYNC_BYTE);
    bad_sum   = byte_valid && (fstate_q == F_SUM) && (sum8(sum_q, byte_data) != 8'h00);
    timeout   = !byte_valid && (fstate_q != F_SYNC) && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
    err_event = bad_sync || bad_sum || timeout;
    err_d     = (err_event && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      fstate_q   <= F_SYNC;
      addr_hi_q  <= 8'h00;
      addr_lo_q  <= 8'h00;
      data_hi_q  <= 8'h00;
      data_lo_q  <= 8'h00;
      sum_q      <= 8'h00;
      tmo_q      <= 16'h0000;
      cfg_addr_q <= 16'h0000;
      cfg_data_q <= 16'h0000;
      strobe_q   <= 1'b0;
      err_q      <= 8'h00;
    end else begin
      strobe_q <= 1'b0;
      err_q    <= err_d;
      if (byte_valid || (fstate_q == F_SYNC) || timeout) tmo_q <= 16'h0000;
      else                                                tmo_q <= tmo_q + 16'd1;
      if (timeout) begin
        fstate_q <= F_SYNC;
      end else if (byte_valid) begin
        case (fstate_q)
          F_SYNC: if (!bad_sync) fstate_q <= F_AH;
          F_AH: begin
            addr_hi_q <= byte_data;
            sum_q     <= byte_data;
            fstate_q  <= F_AL;
          end
          F_AL: begin
            addr_lo_q <= byte_data;
            sum_q     <= sum8(sum_q, byte_data);
            fstate_q  <= F_DH;
          end
          F_DH: begin
            data_hi_q <= byte_data;
            sum_q     <= sum8(sum_q, byte_data);
            fstate_q  <= F_DL;
          end
          F_DL: begin
            data_lo_q <= byte_data;
            sum_q     <= sum8(sum_q, byte_data);
            fstate_q  <= F_SUM;
          end
          F_SUM: begin
            if (!bad_sum) begin
              cfg_addr_q <= {addr_hi_q, addr_lo_q};
              cfg_data_q <= {data_hi_q, data_lo_q};
              strobe_q   <= 1'b1;
            end
            fstate_q <= F_SYNC;
          end
          default: fstate_q <= F_SYNC;
        endcase
      end
    end
  end

  assign config_addr   = cfg_addr_q;
  assign config_data   = cfg_data_q;
  assign config_strobe = strobe_q;
  assign err_count     = err_q;
  assign rx_busy       = (fstate_q != F_SYNC);

endmodule

// File: tb/tb_usb_cmd_rx.sv
// tb/tb_usb_cmd_rx.sv - scoreboard bench for usb_cmd_rx with FT245 FIFO and arbiter models
`timescale 1ns/1ps
module tb_usb_cmd_rx;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  usb_d_in = 8'h00;
  logic        usb_rxf_n = 1'b1;
  logic        usb_rd_n;
  logic        bus_req;
  logic        bus_grant = 1'b0;
  logic [15:0] config_addr, config_data;
  logic        config_strobe;
  logic [7:0]  err_count;
  logic        rx_busy;

  usb_cmd_rx #(.TIMEOUT_CYCLES(100)) dut (
    .mclk         (mclk),
    .reset_n      (reset_n),
    .usb_d_in     (usb_d_in),
    .usb_rxf_n    (usb_rxf_n),
    .usb_rd_n     (usb_rd_n),
    .bus_req      (bus_req),
    .bus_grant    (bus_grant),
    .config_addr  (config_addr),
    .config_data  (config_data),
    .config_strobe(config_strobe),
    .err_count    (err_count),
    .rx_busy      (rx_busy)
  );

  always #8 mclk = ~mclk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  fifo[$];
  logic [31:0] exp_q[$];
  int          grant_delay = 0;
  int          cyc = 0, gcnt = 0, grant_cyc = 0, low_len = 0, hi_len = 99;
  logic        prev_rd = 1'b1;
  logic [7:0]  exp_err = 8'h00;
  logic [15:0] last_addr = 16'h0000, last_data = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic bump_err();
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
  endtask

  task automatic send_frame(input logic [47:0] f);
    logic [7:0] b[6];
    logic [7:0] s;
    for (int i = 0; i < 6; i++) begin
      b[i] = f[47-8*i -: 8];
      fifo.push_back(b[i]);
    end
    s = b[1] + b[2] + b[3] + b[4] + b[5];
    if (s == 8'h00) begin
      exp_q.push_back({b[1], b[2], b[3], b[4]});
      last_addr = {b[1], b[2]};
      last_data = {b[3], b[4]};
    end else begin
      bump_err();
    end
  endtask

  task automatic send_junk(input logic [7:0] b);
    fifo.push_back(b);
    bump_err();
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo.size() != 0 || bus_req || !usb_rd_n) && n < 3000) begin
      tick(1);
      n++;
    end
    chk("drain_done", 32'(n < 3000), 1);
    tick(8);
  endtask

  task automatic check_state();
    chk("pending", 32'(exp_q.size()), 0);
    chk("err_count", 32'(err_count), 32'(exp_err));
    chk("cfg_addr_hold", 32'(config_addr), 32'(last_addr));
    chk("cfg_data_hold", 32'(config_data), 32'(last_data));
    chk("rx_busy_idle", 32'(rx_busy), 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_rd_n", 32'(usb_rd_n), 1);
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_cfg_addr", 32'(config_addr), 0);
    chk("rst_cfg_data", 32'(config_data), 0);
    chk("rst_strobe", 32'(config_strobe), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_busy", 32'(rx_busy), 0);
  endtask

  // FT245 FIFO, bus arbiter, RD# timing monitor and scoreboard output side.
  always @(negedge mclk) begin
    logic [31:0] e;
    cyc++;
    if (!reset_n) begin
      prev_rd   = 1'b1;
      low_len   = 0;
      hi_len    = 99;
      bus_grant = 1'b0;
      gcnt      = 0;
    end else begin
      if (prev_rd && !usb_rd_n) begin
        chk("rd_fall_grant", 32'(bus_grant), 1);
        chk("rd_fall_delay", 32'(cyc - grant_cyc), 1);
        chk("rd_high_min", 32'(hi_len >= 5), 1);
        low_len = 0;
      end
      if (!prev_rd && usb_rd_n) begin
        chk("rd_low_len", 32'(low_len), 4);
        hi_len = 0;
        if (fifo.size() > 0) void'(fifo.pop_front());
      end
      if (!usb_rd_n) low_len++;
      else           hi_len++;
      prev_rd = usb_rd_n;
      if (config_strobe) begin
        chk("strobe_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("cfg_addr", 32'(config_addr), 32'(e[31:16]));
          chk("cfg_data", 32'(config_data), 32'(e[15:0]));
        end
      end
      if (!bus_req) begin
        bus_grant = 1'b0;
        gcnt      = 0;
      end else if (!bus_grant) begin
        if (gcnt >= grant_delay) begin
          bus_grant = 1'b1;
          grant_cyc = cyc;
        end else begin
          gcnt++;
        end
      end
    end
    usb_rxf_n = (fifo.size() == 0);
    usb_d_in  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  initial begin
    int n;
    reset_n = 1'b0;
    tick(3);
    check_reset_vals();
    reset_n = 1'b1;
    tick(2);

    send_frame(48'hC3_00_01_12_34_B9);
    drain();
    check_state();

    send_frame(48'hC3_00_01_12_34_BA);
    drain();
    check_state();
    send_frame(48'hC3_00_01_12_34_B9);
    drain();
    check_state();

    send_junk(8'h55);
    send_junk(8'hAA);
    send_frame(48'hC3_12_34_56_78_EC);
    drain();
    check_state();

    grant_delay = 3;
    send_frame(48'hC3_AB_CD_00_01_87);
    drain();
    check_state();
    grant_delay = 0;

    fifo.push_back(8'hC3);
    fifo.push_back(8'h00);
    drain();
    chk("busy_partial", 32'(rx_busy), 1);
    tick(120);
    bump_err();
    check_state();
    send_frame(48'hC3_00_10_00_20_D0);
    drain();
    check_state();

    send_frame(48'hC3_55_66_77_88_A0);
    n = 0;
    while (usb_rd_n && n < 200) begin
      tick(1);
      n++;
    end
    chk("rd_started", 32'(n < 200), 1);
    tick(1);
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    fifo.delete();
    exp_q.delete();
    exp_err   = 8'h00;
    last_addr = 16'h0000;
    last_data = 16'h0000;
    tick(3);
    reset_n = 1'b1;
    tick(2);
    send_frame(48'hC3_FF_FE_80_01_82);
    drain();
    check_state();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_cmd_rx.md
Name: usb_cmd_rx

Overview:
Host-to-FPGA command receiver, the inbound counterpart of the trace-packet uplink. It reads bytes directly from the FT245 receive FIFO and frames them into checksummed config commands. It emits the config_addr / config_data / config_strobe bus consumed by every usb_config register, including trace flags and the oscillator rate. It shares the FT245 data bus with the transmitter through a simple req/grant handshake.

Parameters:
RD_LOW_CYCLES, 4, mclk cycles usb_rd_n is held low; data is sampled on the last of them (at least 50 ns at 60 MHz).
RD_HIGH_CYCLES, 5, minimum mclk cycles usb_rd_n is high between reads (RD# precharge).
TIMEOUT_CYCLES, 65535, idle mclk cycles allowed between bytes of a partial frame; range 1..65535.
SYNC_BYTE, 8'hC3, frame header byte.

Ports:
mclk  in  1  system clock, 60 MHz
reset_n  in  1  asynchronous, active-low reset
usb_d_in  in  8  FT245 data bus, input path
usb_rxf_n  in  1  FT245 RX-FIFO-not-empty, active low, asynchronous to mclk
usb_rd_n  out  1  FT245 read strobe, active low
bus_req  out  1  request ownership of usb_d
bus_grant  in  1  arbiter grant; usb_d is tri-stated by the transmitter while high
config_addr  out  16  address of the last good command
config_data  out  16  data of the last good command
config_strobe  out  1  one-cycle pulse per good command
err_count  out  8  saturating count of framing, checksum and timeout errors
rx_busy  out  1  high while a frame is partially assembled

Behaviour:
- Reset values: usb_rd_n=1, bus_req=0, config_addr=0, config_data=0, config_strobe=0, err_count=0, rx_busy=0. The byte FSM starts in IDLE and the frame FSM in F_SYNC.
- Reset asserted mid-read forces usb_rd_n=1 immediately (asynchronously) and discards any partial frame.
- usb_rxf_n passes through a 2-flop synchronizer before use. Only the synchronized value is ever sampled.
- Byte FSM:
  - IDLE: when rxf_sync==0, assert bus_req and go to REQ.
  - REQ: on bus_grant==1, drive usb_rd_n=0 and go to STROBE.
  - STROBE: hold usb_rd_n=0 for exactly RD_LOW_CYCLES. Capture usb_d_in on the final cycle and pulse an internal byte_valid the following cycle. Then usb_rd_n=1 and go to RECOVER.
  - RECOVER: hold usb_rd_n=1 for RD_HIGH_CYCLES, then deassert bus_req and return to IDLE. bus_req drops on the same edge the FSM enters IDLE.
- If bus_grant drops during STROBE or RECOVER, the read still completes; the grant is ignored after entry to STROBE. The arbiter is required not to revoke a grant while bus_req is high.
- Frame format: SYNC_BYTE, addr_hi, addr_lo, data_hi, data_lo, sum. A frame is valid when (addr_hi+addr_lo+data_hi+data_lo+sum) mod 256 == 0.
- Frame FSM, advanced on byte_valid: F_SYNC -> F_AH -> F_AL -> F_DH -> F_DL -> F_SUM -> F_SYNC.
  - In F_SYNC, a non-SYNC byte is discarded, err_count increments, and the FSM stays in F_SYNC.
  - rx_busy = (state != F_SYNC).
- Good sum: on the cycle after the sum byte's byte_valid, config_addr and config_data update and config_strobe=1 for exactly one cycle.
- Bad sum: no strobe, outputs hold, err_count increments.
- Timeout: a 16-bit counter clears on each byte_valid and counts while rx_busy. On reaching TIMEOUT_CYCLES the FSM returns to F_SYNC and err_count increments.
- err_count saturates at 8'hFF.
- Simultaneous bad sum and timeout on the same cycle count as a single error.
- Minimum byte period is 2+RD_LOW_CYCLES+RD_HIGH_CYCLES+1 cycles, so config_strobe can never occur on consecutive cycles.

Decomposition:
- Shared package usb_proto_defs holds SYNC_BYTE, the frame length (6), the frame-state encodings, and the trace packet type codes (address 00, read 01, write 10, timestamp 11) so uplink and downlink share one definition.
- Sub-module ft245_rx_byte contains the synchronizer, byte FSM and read timing. It outputs byte_data[7:0] and byte_valid.
- The top level holds the frame FSM, checksum, timeout and error counter.

Test Plan:
- Good frame: rxf_n low with bytes C3 00 01 12 34 B9, grant immediate -> one config_strobe with config_addr=0x0001, config_data=0x1234; err_count=0.
- Bad checksum: C3 00 01 12 34 BA -> no strobe, config_addr/config_data unchanged, err_count=1. Then the good frame above -> strobe, err_count stays 1.
- Resync: 55 AA followed by the good frame -> err_count=2 and exactly one strobe with the correct values.
- Read timing: bus_grant delayed 3 cycles after bus_req -> usb_rd_n low exactly 4 cycles starting the cycle after grant, high at least 5 cycles. usb_rd_n never falls while bus_grant==0.
- Timeout: TIMEOUT_CYCLES=100; send C3 00, then hold rxf_n high for 120 cycles -> rx_busy falls, err_count=1. A following good frame is accepted.
- Reset mid-read: assert reset_n low during STROBE -> usb_rd_n=1 and all outputs at reset values within the same cycle. A frame sent after reset release is accepted.
